// File: rtl/seq_divider.sv
// Sequential unsigned radix-2 restoring divider: one quotient bit per clock
// behind a start/done handshake, with a divide-by-zero shortcut.
//
// state | meaning
// IDLE  | waiting for start; the done pulse for the previous result shows here
// RUN   | N shift/compare/subtract iterations, one per clock
// FIN   | one busy cycle that commits the divide-by-zero result
module seq_divider #(
  parameter int N = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         dbz
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t        state, state_nxt;
  logic          done_nxt;
  logic [N-1:0]  q_sr, d_reg, rem;
  logic [N:0]    rem_sh;
  logic [N-1:0]  rem_diff, rem_nxt, q_nxt;
  logic          sub_msb_unused;
  logic          ge, last;
  logic [CW-1:0] count;

  // rem < B is invariant, so N bits hold it; only the shifted value needs N+1
  assign rem_sh = {rem, q_sr[N-1]};
  assign ge = rem_sh >= {1'b0, d_reg};
  assign {sub_msb_unused, rem_diff} = rem_sh - {1'b0, d_reg};
  assign rem_nxt = ge ? rem_diff : rem_sh[N-1:0];
  assign q_nxt = {q_sr[N-2:0], ge};
  assign last = (count == CW'(N - 1));
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // done is registered so it appears on the first cycle back in IDLE,
  // which lets the next accept follow the result with no dead cycle
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = (B != '0) ? RUN : FIN;
      RUN: begin
        if (last) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      FIN: begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sr  <= '0;
      d_reg <= '0;
      rem   <= '0;
      count <= '0;
      Q     <= '0;
      R     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            q_sr  <= A;
            d_reg <= B;
            rem   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          q_sr  <= q_nxt;
          rem   <= rem_nxt;
          count <= count + 1'b1;
          if (last) begin
            Q   <= q_nxt;
            R   <= rem_nxt;
            dbz <= 1'b0;
          end
        end
        FIN: begin
          Q   <= '1;
          R   <= q_sr;
          dbz <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: the driver queues expected results from a
// plain-arithmetic model, the monitor checks them on every done pulse.
module tb_seq_divider;
  localparam int N = 128;
  localparam logic [N-1:0] ALL1 = '1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0;
  logic [N-1:0] B = '0;
  logic         busy, done, dbz;
  logic [N-1:0] Q, R;

  always #5 clk = ~clk;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .Q(Q), .R(R), .dbz(dbz)
  );

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int done_count = 0;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == '0) begin
      e.q = ALL1;
      e.r = a;
      e.z = 1'b1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 1'b0;
    end
    return e;
  endfunction

  function automatic logic [N-1:0] rnd_op();
    logic [N-1:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    return v >> $urandom_range(0, N - 1);
  endfunction

  // monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_count++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done with empty scoreboard, want none");
      end else begin
        exp_t e;
        logic [2*N-1:0] recon;
        e = sb.pop_front();
        chk("quotient", Q, e.q);
        chk("remainder", R, e.r);
        chk("dbz", N'(dbz), N'(e.z));
        chk("busy_with_done", N'(busy), N'(0));
        if (!e.z) begin
          recon = (2*N)'(Q) * (2*N)'(e.b) + (2*N)'(R);
          total++;
          if (recon !== (2*N)'(e.a)) begin
            bad++;
            $display("FAIL identity: got Q*B+R=%0h want A=%0h", recon, e.a);
          end
          chk("r_lt_b", N'(R < e.b), N'(1));
        end
      end
    end
  end

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    A = ~a;
    B = ~b;
  endtask

  // counts edges from the current sample point up to the one that raises done
  task automatic wait_done(output int cycles);
    bit busy_ok;
    busy_ok = 1'b1;
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && cycles < N + 8);
    chk("busy_during_op", N'(busy_ok), N'(1));
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done after %0d cycles, want done", cycles);
    end
  endtask

  initial begin
    #(1500000);
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int dc;
    logic [N-1:0] ra, rb;

    #1;
    chk("rst_q", Q, '0);
    chk("rst_r", R, '0);
    chk("rst_dbz", N'(dbz), N'(0));
    chk("rst_busy", N'(busy), N'(0));
    chk("rst_done", N'(done), N'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(100, 7);
    chk("busy_after_accept", N'(busy), N'(1));
    wait_done(c);
    chk("lat_100_7", N'(c), N'(N));
    chk("q_100_7", Q, N'(14));
    chk("r_100_7", R, N'(2));

    issue(ALL1, 1);
    wait_done(c);
    chk("q_max_1", Q, ALL1);
    issue(ALL1, ALL1);
    wait_done(c);
    chk("q_max_max", Q, N'(1));
    chk("r_max_max", R, N'(0));

    issue(5, 9);
    wait_done(c);
    chk("r_5_9", R, N'(5));
    issue(0, 3);
    wait_done(c);

    issue(1234, 0);
    chk("busy_dbz", N'(busy), N'(1));
    wait_done(c);
    chk("lat_dbz", N'(c), N'(1));
    chk("r_dbz", R, N'(1234));
    issue(10, 3);
    wait_done(c);
    chk("lat_after_dbz", N'(c), N'(N));

    // start pulse during RUN must be ignored and results must hold
    issue(100, 7);
    repeat (20) @(posedge clk);
    @(negedge clk);
    A = 55;
    B = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_q", Q, N'(3));
    chk("hold_r", R, N'(1));
    wait_done(c);
    chk("lat_ignored_start", N'(c), N'(N - 21));
    repeat (10) @(posedge clk);

    // reset in the middle of a divide
    issue(100, 7);
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_q", Q, '0);
    chk("abort_r", R, '0);
    chk("abort_busy", N'(busy), N'(0));
    chk("abort_done", N'(done), N'(0));
    sb.delete();
    dc = done_count;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(posedge clk);
    chk("no_done_after_abort", N'(done_count), N'(dc));

    // start held high: accepts every N+1 cycles
    sb.push_back(model(100, 7));
    sb.push_back(model(100, 7));
    sb.push_back(model(100, 7));
    @(negedge clk);
    A = 100;
    B = 7;
    start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(c);
    chk("b2b_first", N'(c), N'(N));
    wait_done(c);
    chk("b2b_period_1", N'(c), N'(N + 1));
    wait_done(c);
    start = 1'b0;
    chk("b2b_period_2", N'(c), N'(N + 1));
    repeat (5) @(posedge clk);

    for (int i = 0; i < 400; i++) begin
      ra = rnd_op();
      rb = rnd_op();
      if (rb == '0 && ($urandom_range(0, 3) != 0)) rb = 1;
      issue(ra, rb);
      wait_done(c);
      chk("lat_random", N'(c), (rb == '0) ? N'(1) : N'(N));
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_empty", N'(sb.size()), N'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
